// File: rtl/scm_bist_pkg.sv
// Shared types for the March C- BIST controller: FSM states, march ops and the
// element table that drives the sequencer.
package scm_bist_pkg;

    localparam int unsigned NUM_ELEMENTS = 6;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_e;

    typedef enum logic [1:0] {W0, W1, R0, R1} march_op_e;

    typedef struct packed {
        logic      down;
        logic      two_ops;
        march_op_e op0;
        march_op_e op1;
    } march_elem_t;

    function automatic march_elem_t march_elem(input logic [2:0] idx);
        march_elem_t e;
        case (idx)
            3'd0:    e = '{down: 1'b0, two_ops: 1'b0, op0: W0, op1: W0};
            3'd1:    e = '{down: 1'b0, two_ops: 1'b1, op0: R0, op1: W1};
            3'd2:    e = '{down: 1'b0, two_ops: 1'b1, op0: R1, op1: W0};
            3'd3:    e = '{down: 1'b1, two_ops: 1'b1, op0: R0, op1: W1};
            3'd4:    e = '{down: 1'b1, two_ops: 1'b1, op0: R1, op1: W0};
            default: e = '{down: 1'b0, two_ops: 1'b0, op0: R0, op1: R0};
        endcase
        return e;
    endfunction

    function automatic logic is_write(input march_op_e op);
        return (op == W0) || (op == W1);
    endfunction

endpackage

// File: rtl/scm_bist_addr_gen.sv
// Up/down address counter for the march sequencer; "last" flags the final
// address in the current direction.
module scm_bist_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_val,
    input  logic                  step,
    input  logic                  down,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else if (load) begin
            addr_q <= load_val;
        end else if (step) begin
            addr_q <= down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
        end
    end

    assign addr = addr_q;
    assign last = down ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/scm_march_bist_ctrl.sv
// March C- BIST controller: sequences 10N memory ops with registered memory
// outputs and checks read data one cycle after each read.
module scm_march_bist_ctrl
    import scm_bist_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 5,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_BYTE   = DATA_WIDTH / 8,
    parameter logic [DATA_WIDTH-1:0] BACKGROUND = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [15:0]           err_cnt,
    output logic                  BIST,
    output logic                  CSN_T,
    output logic                  WEN_T,
    output logic [ADDR_WIDTH-1:0] A_T,
    output logic [DATA_WIDTH-1:0] D_T,
    output logic [NUM_BYTE-1:0]   BE_T,
    input  logic [DATA_WIDTH-1:0] Q_T
);

    function automatic logic [DATA_WIDTH-1:0] pattern(input march_op_e op);
        return ((op == W1) || (op == R1)) ? ~BACKGROUND : BACKGROUND;
    endfunction

    bist_state_e           state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic                  opsel_q, opsel_d;
    logic                  ag_load, ag_step, addr_last;
    logic                  issue, clear;
    logic [ADDR_WIDTH-1:0] addr;
    march_elem_t           cur, nxt;
    march_op_e             cur_op, nxt_op;

    logic                  rd_pend_q;
    logic [DATA_WIDTH-1:0] rd_exp_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [2:0]            rd_elem_q;

    // Counter always holds the address of the op currently on the bus.
    scm_bist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (ag_load),
        .load_val ('0),
        .step     (ag_step),
        .down     (cur.down),
        .addr     (addr),
        .last     (addr_last)
    );

    assign cur    = march_elem(elem_q);
    assign cur_op = opsel_q ? cur.op1 : cur.op0;

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        opsel_d = opsel_q;
        ag_load = 1'b0;
        ag_step = 1'b0;
        issue   = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    elem_d  = '0;
                    opsel_d = 1'b0;
                    ag_load = 1'b1;
                    issue   = 1'b1;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                if (cur.two_ops && !opsel_q) begin
                    opsel_d = 1'b1;
                    issue   = 1'b1;
                end else begin
                    opsel_d = 1'b0;
                    if (!addr_last) begin
                        ag_step = 1'b1;
                        issue   = 1'b1;
                    end else if (elem_q == 3'(NUM_ELEMENTS - 1)) begin
                        // Final M5 step wraps to 0, leaving A_T idle-low.
                        ag_step = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        // Wrap only when the next element keeps the direction.
                        elem_d  = elem_q + 3'd1;
                        ag_step = (march_elem(elem_q + 3'd1).down == cur.down);
                        issue   = 1'b1;
                    end
                end
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
        nxt    = march_elem(elem_d);
        nxt_op = opsel_d ? nxt.op1 : nxt.op0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            elem_q  <= '0;
            opsel_q <= 1'b0;
            CSN_T   <= 1'b1;
            WEN_T   <= 1'b1;
            D_T     <= '0;
            BE_T    <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            opsel_q <= opsel_d;
            CSN_T   <= ~issue;
            WEN_T   <= ~(issue && is_write(nxt_op));
            D_T     <= (issue && is_write(nxt_op)) ? pattern(nxt_op) : '0;
            BE_T    <= issue ? '1 : '0;
        end
    end

    assign A_T = addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_exp_q  <= '0;
            rd_addr_q <= '0;
            rd_elem_q <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            err_cnt   <= '0;
        end else begin
            rd_pend_q <= (state_q == RUN) && !is_write(cur_op);
            rd_exp_q  <= pattern(cur_op);
            rd_addr_q <= addr;
            rd_elem_q <= elem_q;
            if (clear) begin
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_elem <= '0;
                err_cnt   <= '0;
            end else if (rd_pend_q && (Q_T != rd_exp_q)) begin
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
                if (!fail) begin
                    fail      <= 1'b1;
                    fail_addr <= rd_addr_q;
                    fail_elem <= rd_elem_q;
                end
            end
        end
    end

    assign busy = (state_q == RUN) || (state_q == DRAIN);
    assign done = (state_q == DONE);
    assign BIST = busy;

endmodule

// File: tb/tb_scm_march_bist_ctrl.sv
// Bench for scm_march_bist_ctrl: memory models with stuck-at faults and a
// loop-based March C- reference predicting bus traffic and error reports.
module tb_scm_march_bist_ctrl;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int N    = 1 << AW;
    localparam int NOPS = 10 * N;
    localparam logic [DW-1:0] BG1 = 32'hAAAAAAAA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_drv, sel;
    logic start0, start1;
    assign start0 = start_drv & ~sel;
    assign start1 = start_drv & sel;

    logic          busy0, done0, fail0, bist0, csn0, wen0;
    logic [AW-1:0] faddr0, a0;
    logic [2:0]    felem0;
    logic [15:0]   err0;
    logic [DW-1:0] d0, q0;
    logic [3:0]    be0;
    logic          busy1, done1, fail1, bist1, csn1, wen1;
    logic [AW-1:0] faddr1, a1;
    logic [2:0]    felem1;
    logic [15:0]   err1;
    logic [DW-1:0] d1, q1;
    logic [3:0]    be1;

    scm_march_bist_ctrl u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .fail(fail0),
        .fail_addr(faddr0), .fail_elem(felem0), .err_cnt(err0), .BIST(bist0),
        .CSN_T(csn0), .WEN_T(wen0), .A_T(a0), .D_T(d0), .BE_T(be0), .Q_T(q0)
    );

    scm_march_bist_ctrl #(.BACKGROUND(BG1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .fail(fail1),
        .fail_addr(faddr1), .fail_elem(felem1), .err_cnt(err1), .BIST(bist1),
        .CSN_T(csn1), .WEN_T(wen1), .A_T(a1), .D_T(d1), .BE_T(be1), .Q_T(q1)
    );

    logic          o_busy, o_done, o_fail, o_bist, o_csn, o_wen;
    logic [AW-1:0] o_faddr, o_a;
    logic [2:0]    o_felem;
    logic [15:0]   o_err;
    logic [DW-1:0] o_d;
    logic [3:0]    o_be;
    assign o_busy  = sel ? busy1  : busy0;
    assign o_done  = sel ? done1  : done0;
    assign o_fail  = sel ? fail1  : fail0;
    assign o_bist  = sel ? bist1  : bist0;
    assign o_csn   = sel ? csn1   : csn0;
    assign o_wen   = sel ? wen1   : wen0;
    assign o_faddr = sel ? faddr1 : faddr0;
    assign o_a     = sel ? a1     : a0;
    assign o_felem = sel ? felem1 : felem0;
    assign o_err   = sel ? err1   : err0;
    assign o_d     = sel ? d1     : d0;
    assign o_be    = sel ? be1    : be0;

    // Stuck-at cell on memory 0; memory 1 is always fault-free.
    logic f_en, f_val;
    int   f_addr, f_bit;

    function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        if (f_en && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    logic [DW-1:0] mem0 [N];
    logic [DW-1:0] mem1 [N];
    always @(posedge clk) begin
        if (!csn0) begin
            if (!wen0) mem0[a0] <= faulty(int'(a0), d0);
            else       q0 <= mem0[a0];
        end
        if (!csn1) begin
            if (!wen1) mem1[a1] <= d1;
            else       q1 <= mem1[a1];
        end
    end

    // March C- as a table: direction, op count, ops (0=w0 1=w1 2=r0 3=r1).
    int tb_down [6]    = '{0, 0, 0, 1, 1, 0};
    int tb_nops [6]    = '{1, 2, 2, 2, 2, 1};
    int tb_ops  [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 2}};

    logic          exp_we   [NOPS];
    logic [AW-1:0] exp_addr [NOPS];
    logic [DW-1:0] exp_data [NOPS];
    int            m_err, m_faddr, m_felem, m_reads;
    logic [DW-1:0] last_d_c1, last_d_m1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_model(input logic [DW-1:0] bg);
        logic [DW-1:0] m [N];
        logic [DW-1:0] pat;
        int k, a, op;
        k = 0;
        m_err = 0; m_faddr = 0; m_felem = 0; m_reads = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                a = (tb_down[e] != 0) ? N - 1 - i : i;
                for (int o = 0; o < tb_nops[e]; o++) begin
                    op  = tb_ops[e][o];
                    pat = (op == 1 || op == 3) ? ~bg : bg;
                    exp_addr[k] = AW'(a);
                    exp_we[k]   = (op < 2);
                    exp_data[k] = (op < 2) ? pat : '0;
                    if (op < 2) begin
                        m[a] = faulty(a, pat);
                    end else begin
                        m_reads++;
                        if (m[a] !== pat) begin
                            if (m_err == 0) begin
                                m_faddr = a;
                                m_felem = e;
                            end
                            m_err++;
                        end
                    end
                    k++;
                end
            end
        end
    endtask

    task automatic run_check(input logic [DW-1:0] bg, input int repulse);
        int bus_err, rd_seen;
        logic idle_busy;
        bus_err = 0;
        rd_seen = 0;
        build_model(bg);
        @(negedge clk); start_drv = 1'b1;
        @(negedge clk); start_drv = 1'b0;
        for (int c = 1; c <= NOPS + 2; c++) begin
            if (c == 1) check("flags_clear", {o_done, o_fail, o_err}, 0);
            if (c <= NOPS) begin
                if (o_csn !== 1'b0 || o_wen !== !exp_we[c-1] || o_a !== exp_addr[c-1] ||
                    o_d !== exp_data[c-1] || o_be !== 4'hF || o_busy !== 1'b1 ||
                    o_bist !== 1'b1 || o_done !== 1'b0) bus_err++;
                if (o_csn === 1'b0 && o_wen === 1'b1) rd_seen++;
            end else begin
                idle_busy = (c == NOPS + 1);
                if (o_csn !== 1'b1 || o_wen !== 1'b1 || o_a !== '0 || o_d !== '0 ||
                    o_be !== '0 || o_bist !== idle_busy || o_busy !== idle_busy) bus_err++;
            end
            if (c == 1)     last_d_c1 = o_d;
            if (c == N + 2) last_d_m1 = o_d;
            start_drv = (c == repulse);
            if (c < NOPS + 2) @(negedge clk);
        end
        start_drv = 1'b0;
        check("bus_seq", bus_err, 0);
        check("read_count", rd_seen, m_reads);
        check("done", o_done, 1);
        check("busy_end", o_busy, 0);
        check("fail", o_fail, (m_err != 0));
        check("err_cnt", o_err, m_err);
        check("fail_addr", o_faddr, m_faddr);
        check("fail_elem", o_felem, m_felem);
    endtask

    initial begin
        int acc;
        rst = 1'b1; start_drv = 1'b0; sel = 1'b0;
        f_en = 1'b0; f_addr = 0; f_bit = 0; f_val = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_flags", {o_busy, o_done, o_fail, o_bist, o_faddr, o_felem, o_err}, 0);
        check("rst_bus", {o_csn, o_wen, o_a, o_d, o_be}, {2'b11, {(AW + DW + 4){1'b0}}});

        run_check('0, 0);
        check("req031_err", o_err, 0);

        f_en = 1'b1; f_addr = 7; f_bit = 3; f_val = 1'b0;
        run_check('0, 0);
        check("sa0_result", {o_fail, o_faddr, o_felem, o_err}, {1'b1, 5'd7, 3'd2, 16'd2});

        f_addr = 31; f_bit = 0; f_val = 1'b1;
        run_check('0, 0);
        check("sa1_result", {o_fail, o_faddr, o_felem, o_err}, {1'b1, 5'd31, 3'd1, 16'd3});

        f_en = 1'b0;
        run_check('0, 50);

        // Abort with an already-reported fault; rst must wipe everything.
        f_en = 1'b1; f_addr = 2; f_bit = 0; f_val = 1'b1;
        @(negedge clk); start_drv = 1'b1;
        @(negedge clk); start_drv = 1'b0;
        repeat (99) @(negedge clk);
        check("pre_abort_err", o_err, 1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("abort_state", {o_csn, o_bist, o_busy, o_done, o_err, o_fail},
              {1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0});
        acc = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_csn !== 1'b1) acc++;
        end
        check("abort_no_access", acc, 0);

        f_en = 1'b0;
        run_check('0, 0);

        for (int r = 0; r < 4; r++) begin
            f_en   = 1'b1;
            f_addr = int'($urandom_range(N - 1, 0));
            f_bit  = int'($urandom_range(DW - 1, 0));
            f_val  = 1'($urandom_range(1, 0));
            run_check('0, int'($urandom_range(NOPS, 2)));
        end

        f_en = 1'b0;
        sel  = 1'b1;
        run_check(BG1, 0);
        check("bg_m0_data", last_d_c1, 32'hAAAAAAAA);
        check("bg_m1_data", last_d_m1, 32'h55555555);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scm_march_bist_ctrl.md
SCM_MARCH_BIST_CTRL -- requirements
Module: scm_march_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, address width of the memory under test (N = 2**ADDR_WIDTH words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-003 SHALL have parameter NUM_BYTE, default DATA_WIDTH/8, number of byte enables.
REQ-004 SHALL have parameter BACKGROUND, default all-zeros (DATA_WIDTH bits), the "0" data pattern; "1" is ~BACKGROUND.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock), rst input 1 (synchronous active-high reset).
REQ-006 start input 1: request one March C- run.
REQ-007 busy output 1: run in progress.
REQ-008 done output 1: run complete; level, held until next accepted start or rst.
REQ-009 fail output 1: sticky, at least one read mismatch in the current or last run.
REQ-010 fail_addr output ADDR_WIDTH: address of the first mismatch.
REQ-011 fail_elem output 3: March element index (0..5) of the first mismatch.
REQ-012 err_cnt output 16: mismatch count, saturating.
REQ-013 BIST output 1: test-mode select to the memory wrapper.
REQ-014 CSN_T output 1: active-low chip select; WEN_T output 1: 0 = write, 1 = read.
REQ-015 A_T output ADDR_WIDTH, D_T output DATA_WIDTH, BE_T output NUM_BYTE: address, write data, byte enables.
REQ-016 Q_T input DATA_WIDTH: read data from the memory, valid one cycle after the read cycle.

Function
REQ-017 SHALL have the FSM states IDLE, RUN, DRAIN and DONE; rst forces IDLE.
REQ-018 start SHALL be accepted in IDLE or DONE; on acceptance done, fail, fail_addr, fail_elem and err_cnt SHALL clear and the FSM SHALL enter RUN. start SHALL be ignored in RUN and DRAIN.
REQ-019 The run SHALL execute March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0).
REQ-020 Up order SHALL be 0..N-1 and down order N-1..0, with both ops of an element done at one address before the next address.
REQ-021 Timing SHALL be one op per cycle with no idle cycles, giving 10N ops. With start sampled at the end of cycle 0, op n SHALL drive cycle n+1.
REQ-022 All memory-side outputs SHALL be registered. During an op CSN_T=0 and BE_T=all ones. Writes SHALL drive WEN_T=0 and D_T=pattern. Reads SHALL drive WEN_T=1 and D_T=0.
REQ-023 For a read in cycle c, Q_T SHALL be compared over the full width with the expected pattern at the end of cycle c+1. On mismatch err_cnt SHALL increment, saturating at 16'hFFFF, and fail SHALL set. fail_addr and fail_elem SHALL latch only on the first mismatch.
REQ-024 After the last op the FSM SHALL enter DRAIN for one cycle (the final compare), then DONE. done=1 and busy=0 from cycle 10N+2. busy=1 in cycles 1..10N+1.
REQ-025 BIST SHALL equal busy. Outside RUN: CSN_T=1, WEN_T=1, A_T=0, D_T=0, BE_T=0.
REQ-026 Address counter wrap (N-1 to 0, or 0 to N-1) SHALL occur only at an element boundary, and SHALL coincide with the element index advance.

Reset
REQ-027 When rst is high at a clock edge, the next cycle SHALL have busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, err_cnt=0, BIST=0, CSN_T=1, WEN_T=1, A_T=0, D_T=0 and BE_T=0.
REQ-028 rst mid-run SHALL abort with no further memory access. Memory contents are then undefined, and a pending compare SHALL be discarded.

Structure
REQ-029 Package scm_bist_pkg SHALL hold the FSM state enum, the march op enum (W0, W1, R0, R1), the element table (direction plus ops per element), and NUM_ELEMENTS = 6.
REQ-030 Sub-module scm_bist_addr_gen SHALL be an up/down address counter with load, step and "last" flag outputs.

Verification
REQ-031 Fault-free memory model, ADDR_WIDTH=5, start pulse: 320 ops, 160 reads; done=1 at cycle 322; fail=0, err_cnt=0.
REQ-032 Bit 3 stuck-at-0 at address 7, BACKGROUND=0: fail=1, fail_addr=7, fail_elem=2, err_cnt=2 (M2, M4).
REQ-033 Bit 0 stuck-at-1 at address 31: fail_addr=31, fail_elem=1, err_cnt=3 (M1, M3, M5).
REQ-034 BACKGROUND=32'hAAAAAAAA: M0 writes drive D_T=AAAAAAAA; M1 writes drive 55555555; the run passes.
REQ-035 start re-pulsed at cycle 50 of a run: ignored, done still at cycle 322. start in DONE: flags clear and a new run begins.
REQ-036 rst at cycle 100: next cycle CSN_T=1, BIST=0, busy=0, done=0, err_cnt=0. A following start completes normally.
